// File: rtl/poly_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : poly_job_scheduler
// Purpose : Round-robin job arbiter and fixed 9-step sequencer driving the
//           8-bit polynomial datapath to compute A*X^2+B*X+C per job.
// Rev     : 1.0  initial release
// ============================================================================
module poly_job_scheduler #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_job,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 busy,
  output logic [7:0]           dp_data_in,
  output logic                 dp_ld_a,
  output logic                 dp_ld_b,
  output logic                 dp_ld_c,
  output logic                 dp_ld_x,
  output logic                 dp_ld_r,
  output logic                 dp_ld_alu_out,
  output logic [1:0]           dp_sel_a,
  output logic [1:0]           dp_sel_b,
  output logic                 dp_alu_op,
  input  logic [7:0]           dp_result
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LD_A    = 4'd1,
    S_LD_B    = 4'd2,
    S_LD_C    = 4'd3,
    S_LD_X    = 4'd4,
    S_MUL_AX  = 4'd5,
    S_MUL_AXX = 4'd6,
    S_MUL_BX  = 4'd7,
    S_ADD_AB  = 4'd8,
    S_ADD_C   = 4'd9,
    S_CAPT    = 4'd10,
    S_RESP    = 4'd11
  } state_t;

  localparam logic [1:0] c_SEL_A = 2'd0;
  localparam logic [1:0] c_SEL_B = 2'd1;
  localparam logic [1:0] c_SEL_C = 2'd2;
  localparam logic [1:0] c_SEL_X = 2'd3;

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_job;
  logic [ID_W-1:0] w_grant;
  logic            w_grant_vld;
  logic            w_accept;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_grant_vld && req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = ID_W'(idx);
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_grant_vld;
  assign req_ready = w_accept ? (N_REQ'(1) << w_grant) : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_LD_A;
      S_LD_A:    w_next = S_LD_B;
      S_LD_B:    w_next = S_LD_C;
      S_LD_C:    w_next = S_LD_X;
      S_LD_X:    w_next = S_MUL_AX;
      S_MUL_AX:  w_next = S_MUL_AXX;
      S_MUL_AXX: w_next = S_MUL_BX;
      S_MUL_BX:  w_next = S_ADD_AB;
      S_ADD_AB:  w_next = S_ADD_C;
      S_ADD_C:   w_next = S_CAPT;
      S_CAPT:    w_next = S_RESP;
      S_RESP:    if (resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath strobes decode from state only, so they never glitch on inputs.
  always_comb begin
    dp_data_in    = 8'd0;
    dp_ld_a       = 1'b0;
    dp_ld_b       = 1'b0;
    dp_ld_c       = 1'b0;
    dp_ld_x       = 1'b0;
    dp_ld_r       = 1'b0;
    dp_ld_alu_out = 1'b0;
    dp_sel_a      = c_SEL_A;
    dp_sel_b      = c_SEL_A;
    dp_alu_op     = 1'b0;
    resp_valid    = (r_state == S_RESP);
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_LD_A: begin dp_ld_a = 1'b1; dp_data_in = r_job[31:24]; end
      S_LD_B: begin dp_ld_b = 1'b1; dp_data_in = r_job[23:16]; end
      S_LD_C: begin dp_ld_c = 1'b1; dp_data_in = r_job[15:8];  end
      S_LD_X: begin dp_ld_x = 1'b1; dp_data_in = r_job[7:0];   end
      S_MUL_AX, S_MUL_AXX: begin
        dp_ld_a = 1'b1; dp_ld_alu_out = 1'b1;
        dp_sel_a = c_SEL_A; dp_sel_b = c_SEL_X; dp_alu_op = 1'b1;
      end
      S_MUL_BX: begin
        dp_ld_b = 1'b1; dp_ld_alu_out = 1'b1;
        dp_sel_a = c_SEL_B; dp_sel_b = c_SEL_X; dp_alu_op = 1'b1;
      end
      S_ADD_AB: begin
        dp_ld_a = 1'b1; dp_ld_alu_out = 1'b1;
        dp_sel_a = c_SEL_A; dp_sel_b = c_SEL_B;
      end
      S_ADD_C: begin
        dp_ld_r = 1'b1;
        dp_sel_a = c_SEL_A; dp_sel_b = c_SEL_C;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_id      <= '0;
      r_job     <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_job <= req_job[32*int'(w_grant) +: 32];
        r_id  <= w_grant;
        r_rr  <= (int'(w_grant) == N_REQ - 1) ? '0 : w_grant + ID_W'(1);
      end
      if (r_state == S_CAPT) begin
        resp_data <= dp_result;
        resp_id   <= r_id;
      end
    end
  end

endmodule
`default_nettype wire
